// File: rtl/dtfm_marker_packer.sv
// DTFM link front end: resynchronises dCLK/dFM/dDAT, frames marker + data groups,
// packs the bit stream MSB-first into words and queues them in a show-ahead FIFO.
module dtfm_marker_packer #(
   parameter int             WORD_W     = 12,
   parameter int             M_W        = 31,
   parameter int             B_W        = 13,
   parameter logic [M_W-1:0] M_PAT      = 31'b1111100110100100001010111011000,
   parameter logic [B_W-1:0] B_PAT      = 13'b1111100110101,
   parameter int             GROUP_BITS = 2816,
   parameter int             GROUPS     = 4,
   parameter int             DATA_EDGE  = 0,
   parameter int             FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dCLK,
   input  logic              dFM,
   input  logic              dDAT,
   output logic [WORD_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_frame_start,
   output logic              o_resync,
   output logic              o_overflow
);
   localparam int MK_W  = M_W + B_W;
   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam int MC_W  = $clog2(MK_W + 1);
   localparam int BC_W  = $clog2(GROUP_BITS + 1);
   localparam int G_W   = $clog2(GROUPS) + 1;
   localparam int A_W   = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] PACK_LAST = CNT_W'(WORD_W - 1);
   localparam logic [MC_W-1:0]  MK_LAST   = MC_W'(MK_W - 1);
   localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(GROUP_BITS - 1);
   localparam logic [G_W-1:0]   G_LAST    = G_W'(GROUPS - 1);

   typedef enum logic [1:0] {WAIT_SYNC, WRITE_MARKER, WRITE_DATA, FLUSH} state_t;

   state_t            state, nextState;
   logic [2:0]        clkSync, fmSync;
   logic [1:0]        datSync;
   logic              syncFront, dataEdge, datBit;
   logic              restart, resyncHit, markStep, dataStep, groupDone, flushPush;
   logic              shiftBit, bitVal, wordDone, pushReq, pushOk, pop;
   logic [G_W-1:0]    grp;
   logic [BC_W-1:0]   groupCnt;
   logic [MC_W-1:0]   markCnt;
   logic [MK_W-1:0]   markerReg;
   logic [WORD_W-1:0] packReg, pushWord;
   logic [CNT_W-1:0]  packCnt, padShift;
   logic              firstPending;
   logic [WORD_W:0]   mem [FIFO_DEPTH];
   logic [A_W:0]      wrPtr, rdPtr;
   logic [WORD_W:0]   headEntry;
   logic              empty, full;

   function automatic logic [MK_W-1:0] markerFor(input logic [G_W-1:0] g);
      return {g[0] ? ~M_PAT : M_PAT, g[1] ? ~B_PAT : B_PAT};
   endfunction

   // dDAT gets one stage less so its s[1] lines up with dCLK's s[1]
   always_ff @(posedge clk) begin
      clkSync <= {clkSync[1:0], dCLK};
      fmSync  <= {fmSync[1:0], dFM};
      datSync <= {datSync[0], dDAT};
   end

   assign syncFront = fmSync[1] & ~fmSync[2];
   assign dataEdge  = (DATA_EDGE != 0) ? (clkSync[1] & ~clkSync[2]) : (clkSync[2] & ~clkSync[1]);
   assign datBit    = datSync[1];

   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_SYNC;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      restart   = 1'b0;
      resyncHit = 1'b0;
      markStep  = 1'b0;
      dataStep  = 1'b0;
      groupDone = 1'b0;
      flushPush = 1'b0;
      case (state)
         WAIT_SYNC: begin
            if (syncFront) begin
               restart   = 1'b1;
               nextState = WRITE_MARKER;
            end
         end
         WRITE_MARKER: begin
            if (syncFront) begin
               restart   = 1'b1;
               resyncHit = 1'b1;
            end else begin
               markStep = 1'b1;
               if (markCnt == MK_LAST) nextState = WRITE_DATA;
            end
         end
         WRITE_DATA: begin
            // a sync front outranks a coincident data edge
            if (syncFront) begin
               restart   = 1'b1;
               resyncHit = 1'b1;
               nextState = WRITE_MARKER;
            end else if (dataEdge) begin
               dataStep = 1'b1;
               if (groupCnt == BC_LAST) begin
                  groupDone = 1'b1;
                  nextState = (grp == G_LAST) ? FLUSH : WRITE_MARKER;
               end
            end
         end
         FLUSH: begin
            if (syncFront) begin
               restart   = 1'b1;
               resyncHit = 1'b1;
               nextState = WRITE_MARKER;
            end else begin
               flushPush = (packCnt != '0);
               nextState = WAIT_SYNC;
            end
         end
         default: nextState = WAIT_SYNC;
      endcase
   end

   assign shiftBit = markStep | dataStep;
   assign bitVal   = markStep ? markerReg[MK_W-1] : datBit;
   assign wordDone = shiftBit && (packCnt == PACK_LAST);
   assign pushReq  = wordDone | flushPush;
   assign padShift = CNT_W'(WORD_W) - packCnt;
   assign pushWord = flushPush ? (packReg << padShift) : {packReg[WORD_W-2:0], bitVal};

   always_ff @(posedge clk) begin
      if (reset) begin
         grp          <= '0;
         groupCnt     <= '0;
         markCnt      <= '0;
         markerReg    <= '0;
         packReg      <= '0;
         packCnt      <= '0;
         firstPending <= 1'b0;
         o_resync     <= 1'b0;
      end else begin
         o_resync <= resyncHit;
         if (restart) begin
            grp          <= '0;
            groupCnt     <= '0;
            markCnt      <= '0;
            markerReg    <= markerFor('0);
            packReg      <= '0;
            packCnt      <= '0;
            firstPending <= 1'b1;
         end else begin
            if (markStep) begin
               markerReg <= markerReg << 1;
               markCnt   <= (markCnt == MK_LAST) ? '0 : markCnt + MC_W'(1);
            end
            if (dataStep) begin
               groupCnt <= groupDone ? '0 : groupCnt + BC_W'(1);
               if (groupDone) begin
                  grp       <= grp + G_W'(1);
                  markerReg <= markerFor(grp + G_W'(1));
               end
            end
            if (shiftBit) begin
               packReg <= {packReg[WORD_W-2:0], bitVal};
               packCnt <= wordDone ? '0 : packCnt + CNT_W'(1);
            end
            if (flushPush) begin
               packReg <= '0;
               packCnt <= '0;
            end
            if (pushReq) firstPending <= 1'b0;
         end
      end
   end

   // FIFO entries carry the frame-start tag above the data word
   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[A_W] != rdPtr[A_W]) && (wrPtr[A_W-1:0] == rdPtr[A_W-1:0]);
   assign pop    = !empty && i_ready;
   assign pushOk = pushReq && (!full || pop);

   always_ff @(posedge clk) begin
      if (pushOk && !reset) mem[wrPtr[A_W-1:0]] <= {firstPending, pushWord};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (pushOk)            wrPtr      <= wrPtr + (A_W+1)'(1);
         if (pop)               rdPtr      <= rdPtr + (A_W+1)'(1);
         if (pushReq && !pushOk) o_overflow <= 1'b1;
      end
   end

   assign headEntry     = mem[rdPtr[A_W-1:0]];
   assign o_valid       = !empty;
   assign o_data        = empty ? '0 : headEntry[WORD_W-1:0];
   assign o_frame_start = !empty && headEntry[WORD_W];
endmodule
